// File: rtl/vend_ctrl.sv
// vend_ctrl: keypad-driven vending controller with a debounced key front end,
// credit accumulation, item dispense and change refund.
// Optional feature: define VEND_TIMEOUT_EN to refund credit automatically after
// TIMEOUT_CYC idle cycles in CREDIT. Without it, credit is held indefinitely.
module vend_ctrl #(
    parameter int DEB_CYC     = 20,
    parameter int DISP_CYC    = 8,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    output logic [4:0] credit,
    output logic [2:0] item,
    output logic       dispense,
    output logic [4:0] change,
    output logic       change_valid,
    output logic       reject,
    output logic       busy
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int PW = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYC);
    localparam logic [PW-1:0] DISP_LAST  = PW'(DISP_CYC - 1);
    localparam logic [5:0]    CREDIT_MAX = 6'd20;

    if (DEB_CYC < 2 || DISP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("vend_ctrl: DEB_CYC must be >= 2, DISP_CYC and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    // Coin keys map to their face value; every other key is worth nothing.
    function automatic logic [4:0] coin_value(input logic [3:0] k);
        case (k)
            4'h8:    coin_value = 5'd1;
            4'h9:    coin_value = 5'd2;
            4'hA:    coin_value = 5'd5;
            default: coin_value = 5'd0;
        endcase
    endfunction

    // Item k costs k+1 coin units.
    function automatic logic [4:0] item_price(input logic [2:0] k);
        item_price = {2'b00, k} + 5'd1;
    endfunction

    // ---------------------------------------------------------------- debounce
    logic [DW-1:0] stab_q, stab_d;
    logic [DW-1:0] rel_q, rel_d;
    logic [3:0]    val_q;
    logic          armed_q, armed_d;
    logic          ev;

    // Count consecutive stable-pressed and released cycles; fire one event per press.
    always_comb begin
        stab_d  = '0;
        rel_d   = '0;
        armed_d = armed_q;
        ev      = 1'b0;
        if (key_valid) begin
            if (stab_q != '0 && key_value == val_q) begin
                stab_d = (stab_q == DEB_MAX) ? DEB_MAX : stab_q + 1'b1;
            end else begin
                stab_d = DW'(1);
            end
        end else begin
            rel_d = (rel_q == DEB_MAX) ? DEB_MAX : rel_q + 1'b1;
        end
        if (armed_q && stab_d == DEB_MAX) begin
            ev      = 1'b1;
            armed_d = 1'b0;
        end else if (!armed_q && rel_d == DEB_MAX) begin
            armed_d = 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab_q  <= '0;
            rel_q   <= '0;
            val_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            stab_q  <= stab_d;
            rel_q   <= rel_d;
            val_q   <= key_value;
            armed_q <= armed_d;
        end
    end

    // ---------------------------------------------------------------- key decode
    logic       ev_coin, ev_item, ev_cancel;
    logic [4:0] coin;
    logic [4:0] price;
    logic [5:0] coin_sum;

    assign coin      = coin_value(key_value);
    assign price     = item_price(key_value[2:0]);
    assign ev_coin   = ev && (coin != 5'd0);
    assign ev_item   = ev && !key_value[3];
    assign ev_cancel = ev && (key_value == 4'hC);

    // ---------------------------------------------------------------- control FSM
    state_t        state_q, state_d;
    logic [4:0]    credit_q, credit_d;
    logic [2:0]    item_q, item_d;
    logic [4:0]    change_q, change_d;
    logic          reject_q, reject_d;
    logic [PW-1:0] disp_cnt_q, disp_cnt_d;

    assign coin_sum = {1'b0, credit_q} + {1'b0, coin};

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_q, to_d;

    // Idle-cycle counter; only runs in CREDIT and reloads on any key event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`endif

    // Next-state, credit bookkeeping and strobe generation.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        item_d     = item_q;
        change_d   = change_q;
        reject_d   = 1'b0;
        disp_cnt_d = '0;
`ifdef VEND_TIMEOUT_EN
        to_d       = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ev_coin) begin
                    credit_d = coin;
                    state_d  = S_CREDIT;
                end else if (ev_item) begin
                    reject_d = 1'b1;
                end
            end
            S_CREDIT: begin
                if (ev_coin) begin
                    // Over-limit coins are refused outright, never clipped.
                    if (coin_sum <= CREDIT_MAX) begin
                        credit_d = coin_sum[4:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (ev_item) begin
                    if (credit_q >= price) begin
                        item_d   = key_value[2:0];
                        credit_d = credit_q - price;
                        state_d  = S_DISPENSE;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (ev_cancel) begin
                    state_d = S_CHANGE;
                end
`ifdef VEND_TIMEOUT_EN
                // A key event in the expiry cycle wins: to_d stays at its reload value.
                else if (!ev) begin
                    if (to_q == TO_LAST) begin
                        state_d = S_CHANGE;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
`endif
            end
            S_DISPENSE: begin
                if (disp_cnt_q == DISP_LAST) begin
                    state_d = (credit_q != 5'd0) ? S_CHANGE : S_IDLE;
                end else begin
                    disp_cnt_d = disp_cnt_q + 1'b1;
                end
            end
            S_CHANGE: begin
                credit_d = 5'd0;
                state_d  = S_IDLE;
            end
        endcase
        // The refund amount is captured on entry to CHANGE and then held.
        if (state_d == S_CHANGE && state_q != S_CHANGE) begin
            change_d = credit_q;
        end
    end

    // FSM and output registers; reset discards credit without a refund.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            item_q     <= '0;
            change_q   <= '0;
            reject_q   <= 1'b0;
            disp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            item_q     <= item_d;
            change_q   <= change_d;
            reject_q   <= reject_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    assign credit       = credit_q;
    assign item         = item_q;
    assign change       = change_q;
    assign reject       = reject_q;
    assign dispense     = (state_q == S_DISPENSE);
    assign change_valid = (state_q == S_CHANGE);
    assign busy         = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scenario tasks plus randomized key traffic for vend_ctrl,
// checked against a history-based behavioural model of the vending rules.
module tb_vend_ctrl;

    localparam int DEB  = 4;
    localparam int DISP = 3;
    localparam int TO   = 50;
`ifdef VEND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = 4'h0;
    logic [4:0] credit;
    logic [2:0] item;
    logic       dispense;
    logic [4:0] change;
    logic       change_valid;
    logic       reject;
    logic       busy;

    vend_ctrl #(.DEB_CYC(DEB), .DISP_CYC(DISP), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .credit      (credit),
        .item        (item),
        .dispense    (dispense),
        .change      (change),
        .change_valid(change_valid),
        .reject      (reject),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [16:0] obs;
    assign obs = {credit, item, dispense, change, change_valid, reject, busy};

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_CREDIT, M_DISP, M_CHANGE} mst_t;
    mst_t ms;
    int   m_credit, m_item, m_change, m_dcnt, m_idle;
    bit   m_reject, m_armed;
    int   hv[$];
    int   hk[$];

    typedef struct {
        bit       v;
        bit [3:0] k;
        int       n;
        int       want_credit;
    } seg_t;

    int n_rej, n_cv, n_disp;

    function automatic seg_t mk(input bit v, input bit [3:0] k, input int n, input int wc);
        seg_t s;
        s.v = v; s.k = k; s.n = n; s.want_credit = wc;
        return s;
    endfunction

    function automatic int coin_of(input int k);
        case (k)
            8:       return 1;
            9:       return 2;
            10:      return 5;
            default: return 0;
        endcase
    endfunction

    function logic [16:0] exp_vec();
        return {5'(m_credit), 3'(m_item), ms == M_DISP, 5'(m_change),
                ms == M_CHANGE, m_reject, (ms == M_DISP) || (ms == M_CHANGE)};
    endfunction

    task automatic model_reset();
        ms = M_IDLE; m_credit = 0; m_item = 0; m_change = 0; m_dcnt = 0; m_idle = 0;
        m_reject = 0; m_armed = 1;
        hv.delete(); hk.delete();
    endtask

    task automatic model_step(input logic v, input logic [3:0] k);
        bit fire, all_on, all_off;
        int kk;
        kk = int'(k);
        hv.push_back(int'(v)); hk.push_back(kk);
        if (hv.size() > DEB) begin
            void'(hv.pop_front()); void'(hk.pop_front());
        end
        all_on  = (hv.size() == DEB);
        all_off = all_on;
        foreach (hv[i]) begin
            if (hv[i] == 0 || hk[i] != kk) all_on = 0;
            if (hv[i] != 0) all_off = 0;
        end
        fire = 0;
        if (m_armed && all_on) begin
            fire = 1; m_armed = 0;
        end else if (!m_armed && all_off) begin
            m_armed = 1;
        end
        m_reject = 0;
        case (ms)
            M_IDLE: begin
                if (fire && coin_of(kk) > 0) begin
                    m_credit = coin_of(kk); ms = M_CREDIT; m_idle = 0;
                end else if (fire && kk < 8) begin
                    m_reject = 1;
                end
            end
            M_CREDIT: begin
                if (fire) begin
                    m_idle = 0;
                    if (coin_of(kk) > 0) begin
                        if (m_credit + coin_of(kk) <= 20) m_credit += coin_of(kk);
                        else m_reject = 1;
                    end else if (kk < 8) begin
                        if (m_credit >= kk + 1) begin
                            m_item = kk; m_credit -= kk + 1; ms = M_DISP; m_dcnt = 0;
                        end else begin
                            m_reject = 1;
                        end
                    end else if (kk == 12) begin
                        m_change = m_credit; ms = M_CHANGE;
                    end
                end else if (TO_EN) begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_change = m_credit; ms = M_CHANGE;
                    end
                end
            end
            M_DISP: begin
                m_dcnt++;
                if (m_dcnt == DISP) begin
                    if (m_credit > 0) begin
                        m_change = m_credit; ms = M_CHANGE;
                    end else begin
                        ms = M_IDLE;
                    end
                end
            end
            M_CHANGE: begin
                m_credit = 0; ms = M_IDLE;
            end
        endcase
    endtask

    // One clock cycle of stimulus; the model advances on the same edge.
    task automatic cyc(input logic v, input logic [3:0] k);
        key_valid = v;
        key_value = k;
        @(posedge clk);
        model_step(v, k);
        #1;
        n_rej  += int'(reject);
        n_cv   += int'(change_valid);
        n_disp += int'(dispense);
    endtask

    task automatic clear_counts();
        n_rej = 0; n_cv = 0; n_disp = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        #2;
        total++;
        if (obs !== 17'h0) begin
            bad++; $display("FAIL reset_state: dut=%h want=%h", obs, 17'h0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_debounce();
        seg_t s[$];
        clear_counts();
        s.push_back(mk(1, 4'h9, 3, 0));
        s.push_back(mk(1, 4'h9, 1, 2));
        s.push_back(mk(1, 4'h9, 16, 2));
        s.push_back(mk(0, 4'h0, 4, 2));
        foreach (s[i]) begin
            for (int c = 0; c < s[i].n; c++) begin
                cyc(s[i].v, s[i].k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL debounce seg%0d cyc%0d: dut=%h model=%h", i, c, obs, exp_vec());
                end
            end
            total++;
            if (credit !== 5'(s[i].want_credit)) begin
                bad++; $display("FAIL debounce_credit seg%0d: dut=%0d want=%0d", i, credit, s[i].want_credit);
            end
        end
    endtask

    task automatic test_reject_vend();
        seg_t s[$];
        clear_counts();
        s.push_back(mk(1, 4'h2, 4, 2)); s.push_back(mk(0, 4'h0, 4, 2));
        s.push_back(mk(1, 4'h8, 4, 3)); s.push_back(mk(0, 4'h0, 4, 3));
        s.push_back(mk(1, 4'h2, 4, 0)); s.push_back(mk(0, 4'h0, 6, 0));
        foreach (s[i]) begin
            for (int c = 0; c < s[i].n; c++) begin
                cyc(s[i].v, s[i].k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL reject_vend seg%0d cyc%0d: dut=%h model=%h", i, c, obs, exp_vec());
                end
            end
            total++;
            if (credit !== 5'(s[i].want_credit)) begin
                bad++; $display("FAIL reject_vend_credit seg%0d: dut=%0d want=%0d", i, credit, s[i].want_credit);
            end
        end
        total++;
        if ({n_rej, n_disp, n_cv} !== {32'd1, 32'd3, 32'd0}) begin
            bad++; $display("FAIL reject_vend_strobes: rej=%0d disp=%0d cv=%0d want 1/3/0", n_rej, n_disp, n_cv);
        end
        total++;
        if ({item, busy} !== {3'd2, 1'b0}) begin
            bad++; $display("FAIL reject_vend_item: item=%0d busy=%0d want 2/0", item, busy);
        end
    endtask

    task automatic test_coin_limit();
        seg_t s[$];
        int want[6] = '{5, 10, 11, 12, 17, 17};
        logic [3:0] keys[6] = '{4'hA, 4'hA, 4'h8, 4'h8, 4'hA, 4'hA};
        clear_counts();
        for (int j = 0; j < 6; j++) begin
            s.push_back(mk(1, keys[j], 4, want[j]));
            s.push_back(mk(0, 4'h0, 4, want[j]));
        end
        s.push_back(mk(1, 4'hC, 4, 17)); s.push_back(mk(0, 4'h0, 4, 0));
        foreach (s[i]) begin
            for (int c = 0; c < s[i].n; c++) begin
                cyc(s[i].v, s[i].k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL coin_limit seg%0d cyc%0d: dut=%h model=%h", i, c, obs, exp_vec());
                end
            end
            total++;
            if (credit !== 5'(s[i].want_credit)) begin
                bad++; $display("FAIL coin_limit_credit seg%0d: dut=%0d want=%0d", i, credit, s[i].want_credit);
            end
        end
        total++;
        if ({n_rej, n_cv, 27'd0, change} !== {32'd1, 32'd1, 32'd17}) begin
            bad++; $display("FAIL coin_limit_strobes: rej=%0d cv=%0d change=%0d want 1/1/17", n_rej, n_cv, change);
        end
    endtask

    task automatic test_change();
        seg_t s[$];
        clear_counts();
        s.push_back(mk(1, 4'hA, 4, 5)); s.push_back(mk(0, 4'h0, 4, 5));
        s.push_back(mk(1, 4'h9, 4, 7)); s.push_back(mk(0, 4'h0, 4, 7));
        s.push_back(mk(1, 4'h0, 4, 6)); s.push_back(mk(0, 4'h0, 6, 0));
        foreach (s[i]) begin
            for (int c = 0; c < s[i].n; c++) begin
                cyc(s[i].v, s[i].k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL change seg%0d cyc%0d: dut=%h model=%h", i, c, obs, exp_vec());
                end
            end
            total++;
            if (credit !== 5'(s[i].want_credit)) begin
                bad++; $display("FAIL change_credit seg%0d: dut=%0d want=%0d", i, credit, s[i].want_credit);
            end
        end
        total++;
        if ({n_disp, n_cv, 27'd0, change} !== {32'd3, 32'd1, 32'd6}) begin
            bad++; $display("FAIL change_strobes: disp=%0d cv=%0d change=%0d want 3/1/6", n_disp, n_cv, change);
        end
    endtask

    task automatic test_cancel_timeout();
        seg_t s[$];
        clear_counts();
        s.push_back(mk(1, 4'hA, 4, 5)); s.push_back(mk(0, 4'h0, 4, 5));
        s.push_back(mk(1, 4'hC, 4, 5)); s.push_back(mk(0, 4'h0, 4, 0));
        s.push_back(mk(1, 4'hA, 4, 5)); s.push_back(mk(0, 4'h0, 200, TO_EN ? 0 : 5));
        s.push_back(mk(1, 4'hC, 4, TO_EN ? 0 : 5)); s.push_back(mk(0, 4'h0, 4, 0));
        foreach (s[i]) begin
            for (int c = 0; c < s[i].n; c++) begin
                cyc(s[i].v, s[i].k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL cancel_timeout seg%0d cyc%0d: dut=%h model=%h", i, c, obs, exp_vec());
                end
            end
            total++;
            if (credit !== 5'(s[i].want_credit)) begin
                bad++; $display("FAIL cancel_timeout_credit seg%0d: dut=%0d want=%0d", i, credit, s[i].want_credit);
            end
        end
        total++;
        if ({n_cv, 27'd0, change} !== {32'd2, 32'd5}) begin
            bad++; $display("FAIL cancel_timeout_strobes: cv=%0d change=%0d want 2/5", n_cv, change);
        end
    endtask

    task automatic test_reset_mid_dispense();
        seg_t s[$];
        clear_counts();
        s.push_back(mk(1, 4'hA, 4, 5)); s.push_back(mk(0, 4'h0, 4, 5));
        s.push_back(mk(1, 4'h0, 4, 4)); s.push_back(mk(0, 4'h0, 1, 4));
        foreach (s[i]) begin
            for (int c = 0; c < s[i].n; c++) begin
                cyc(s[i].v, s[i].k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL mid_disp seg%0d cyc%0d: dut=%h model=%h", i, c, obs, exp_vec());
                end
            end
        end
        total++;
        if (dispense !== 1'b1) begin
            bad++; $display("FAIL mid_disp_active: dispense=%0d want 1", dispense);
        end
        // Assert reset between clock edges with a coin key already held.
        key_valid = 1'b1; key_value = 4'h8;
        #2 reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== 17'h0) begin
            bad++; $display("FAIL async_reset: dut=%h want=%h", obs, 17'h0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        clear_counts();
        s.delete();
        s.push_back(mk(1, 4'h8, 3, 0)); s.push_back(mk(1, 4'h8, 1, 1));
        s.push_back(mk(0, 4'h0, 4, 1));
        for (int j = 0; j < 8; j++) begin
            s.push_back(mk(1, 4'h9, 2, 1)); s.push_back(mk(0, 4'h0, 2, 1));
        end
        for (int j = 0; j < 8; j++) begin
            s.push_back(mk(1, 4'h9, 2, 1)); s.push_back(mk(1, 4'h8, 2, 1));
        end
        s.push_back(mk(0, 4'h0, 4, 1));
        s.push_back(mk(1, 4'hC, 4, 1)); s.push_back(mk(0, 4'h0, 4, 0));
        foreach (s[i]) begin
            for (int c = 0; c < s[i].n; c++) begin
                cyc(s[i].v, s[i].k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL bounce seg%0d cyc%0d: dut=%h model=%h", i, c, obs, exp_vec());
                end
            end
            total++;
            if (credit !== 5'(s[i].want_credit)) begin
                bad++; $display("FAIL bounce_credit seg%0d: dut=%0d want=%0d", i, credit, s[i].want_credit);
            end
        end
        total++;
        if ({n_rej, n_cv, 27'd0, change} !== {32'd0, 32'd1, 32'd1}) begin
            bad++; $display("FAIL bounce_strobes: rej=%0d cv=%0d change=%0d want 0/1/1", n_rej, n_cv, change);
        end
    endtask

    task automatic test_random();
        bit       v;
        bit [3:0] k;
        int       n;
        for (int s = 0; s < 220; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                #2 reset = 1'b0;
                model_reset();
                #1;
                total++;
                if (obs !== 17'h0) begin
                    bad++; $display("FAIL random_reset seg%0d: dut=%h want=%h", s, obs, 17'h0);
                end
                @(posedge clk); #1;
                reset = 1'b1;
            end
            v = ($urandom_range(0, 2) != 0);
            k = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 7);
            for (int c = 0; c < n; c++) begin
                cyc(v, k);
                total++;
                if (obs !== exp_vec()) begin
                    bad++; $display("FAIL random seg%0d cyc%0d key=%0d/%h: dut=%h model=%h", s, c, v, k, obs, exp_vec());
                end
            end
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_debounce();
        test_reject_vend();
        test_coin_limit();
        test_change();
        test_cancel_timeout();
        test_reset_mid_dispense();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter: DEB_CYC, default 20, cycles a key input must be stable before it is accepted (min 2).
REQ-002 Parameter: DISP_CYC, default 8, cycles the dispense output is held high (min 1).
REQ-003 Parameter: TIMEOUT_CYC, default 1000, idle cycles in CREDIT before auto-refund (used only with VEND_TIMEOUT_EN).
REQ-004 Port: clk  input  1  single system clock; all logic on posedge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: key_valid  input  1  high while the keypad scanner reports a pressed key.
REQ-007 Port: key_value  input  4  code of the pressed key, 0x0-0xF; meaningful only when key_valid=1.
REQ-008 Port: credit  output  5  current credit in coin units, 0-20.
REQ-009 Port: item  output  3  index of the last vended item.
REQ-010 Port: dispense  output  1  held high for DISP_CYC cycles per vend.
REQ-011 Port: change  output  5  refund amount; valid when change_valid=1.
REQ-012 Port: change_valid  output  1  one-cycle refund strobe.
REQ-013 Port: reject  output  1  one-cycle strobe for a refused key event.
REQ-014 Port: busy  output  1  high in the DISPENSE and CHANGE states.

Function
REQ-015 Debounce: a key event for value V fires in the cycle where key_valid=1 and key_value=V have been stable for DEB_CYC consecutive cycles.
REQ-016 Any change of key_value, or key_valid=0, restarts the stability count.
REQ-017 After an event, no further event fires until key_valid has been 0 for DEB_CYC consecutive cycles, so one press yields exactly one event.
REQ-018 Key map: 0x0-0x7 select item k with price k+1; 0x8 adds coin 1, 0x9 adds coin 2, 0xA adds coin 5; 0xC cancels; 0xB and 0xD-0xF are ignored with no strobe.
REQ-019 States: IDLE, CREDIT, DISPENSE, CHANGE; every effect of an event is visible on the clock edge after the event cycle.
REQ-020 IDLE, coin event: credit set to the coin value, go to CREDIT.
REQ-021 IDLE, item event: reject strobe only.
REQ-022 IDLE, cancel event: no action.
REQ-023 CREDIT, coin event: if credit+coin<=20, credit adds the coin; otherwise reject strobe and credit unchanged (no saturation).
REQ-024 CREDIT, item event with credit>=price: item latched, credit reduced by price, go to DISPENSE.
REQ-025 CREDIT, item event with credit<price: reject strobe, state unchanged.
REQ-026 CREDIT, cancel event: go to CHANGE.
REQ-027 DISPENSE: dispense is high for exactly DISP_CYC cycles; key events are discarded silently.
REQ-028 DISPENSE exit: go to CHANGE if credit>0, else to IDLE.
REQ-029 CHANGE (one cycle): change=credit and change_valid=1; credit cleared on the next edge; go to IDLE.
REQ-030 change holds its last value when change_valid=0.
REQ-031 Key events that fire during CHANGE are discarded.
REQ-032 An event and a timeout expiring in the same cycle: the event wins and the timeout counter reloads.

Reset
REQ-033 reset=0 immediately forces state IDLE, credit=0, item=0, dispense=0, change=0, change_valid=0, reject=0, busy=0, and clears all debounce and timeout counters.
REQ-034 Reset during DISPENSE or CREDIT discards credit with no refund strobe.
REQ-035 After reset release, a key already held must be stable for a full DEB_CYC before it fires.

Configuration
REQ-036 Macro VEND_TIMEOUT_EN defined: in CREDIT, TIMEOUT_CYC consecutive cycles without a key event force a transition to CHANGE (auto-refund).
REQ-037 Macro VEND_TIMEOUT_EN defined: every accepted or rejected event reloads the timeout counter.
REQ-038 Macro VEND_TIMEOUT_EN undefined: no timeout logic, and credit is held in CREDIT indefinitely.

Verification (DEB_CYC=4, DISP_CYC=3, TIMEOUT_CYC=50)
REQ-039 Key 0x9 held 4 cycles then released 4 -> credit=2 one cycle after the event; no repeat while held 20 cycles.
REQ-040 Credit 2, key 0x2 (price 3) -> reject pulse, credit=2; then key 0x8 followed by key 0x2 -> dispense high 3 cycles, item=2, credit=0, return to IDLE with no change_valid.
REQ-041 Keys 0xA, 0xA, 0x8, 0x8 -> credit 5, 10, 11, 12; then keys 0xA, 0xA -> credit 17, then reject with credit held at 17.
REQ-042 Credit 7, key 0x0 -> dispense 3 cycles, then change_valid pulse with change=6, credit=0.
REQ-043 Credit 5, cancel 0xC -> change=5 strobe; with VEND_TIMEOUT_EN, credit 5 left idle 50 cycles -> same refund; without the macro, credit stays 5 after 200 cycles.
REQ-044 reset asserted mid-DISPENSE -> all outputs 0 asynchronously; key bounce (toggling every 2 cycles) -> no event fires.
